// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// master = controller (drives strobes), slave = datapath (drives opcode/irq).
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       irq;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] wreg_dst;
    logic [1:0] wreg_data_sel;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
    logic       imm_com;
    logic       int_save_pc;
    logic [2:0] pc_source;
    logic       in_isr;
    logic       int_ack;
    logic       illegal_op;

    modport master (
        input  opcode, irq,
        output alu_op, alu_src_b, wreg_dst, wreg_data_sel,
        output mem_read, mem_write, i_or_d, reg_write, ir_write,
        output pc_write, pc_write_cond, alu_src_a, imm_com,
        output int_save_pc, pc_source, in_isr, int_ack, illegal_op
    );

    modport slave (
        output opcode, irq,
        input  alu_op, alu_src_b, wreg_dst, wreg_data_sel,
        input  mem_read, mem_write, i_or_d, reg_write, ir_write,
        input  pc_write, pc_write_cond, alu_src_a, imm_com,
        input  int_save_pc, pc_source, in_isr, int_ack, illegal_op
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath, with
// interrupt entry/return sequencing at instruction boundaries.
module multicycle_ctrl #(
    parameter bit         IRQ_EN      = 1'b1,
    parameter logic [5:0] ERET_OPCODE = 6'b010000
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_I_EXEC   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;
    localparam logic [3:0] S_INT      = 4'd13;
    localparam logic [3:0] S_ERET     = 4'd14;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_boundary;
    logic [3:0] w_dec_next;
    logic       w_dec_ill;
    logic       r_in_isr;

    // Where to go after the last state of an instruction.
    always_comb begin
        w_boundary = S_FETCH;
        if (IRQ_EN && bus.irq && !r_in_isr)
            w_boundary = S_INT;
    end

    // Opcode decode used in the DECODE state.
    always_comb begin
        w_dec_next = w_boundary;
        w_dec_ill  = 1'b0;
        case (bus.opcode)
            6'b000000: w_dec_next = S_R_EXEC;
            6'b100011: w_dec_next = S_MEM_ADDR;
            6'b101011: w_dec_next = S_MEM_ADDR;
            6'b000100: w_dec_next = S_BRANCH;
            6'b000010: w_dec_next = S_JUMP;
            6'b000011: w_dec_next = S_JAL;
            6'b001000: w_dec_next = S_I_EXEC;
            6'b001100: w_dec_next = S_I_EXEC;
            6'b001101: w_dec_next = S_I_EXEC;
            6'b001110: w_dec_next = S_I_EXEC;
            6'b001010: w_dec_next = S_I_EXEC;
            default: begin
                if (bus.opcode == ERET_OPCODE && r_in_isr)
                    w_dec_next = S_ERET;
                else
                    w_dec_ill = 1'b1;
            end
        endcase
    end

    // Next-state selection.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE:   w_next = w_dec_next;
            S_MEM_ADDR: w_next = (bus.opcode == 6'b101011) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = S_MEM_WB;
            S_MEM_WB:   w_next = w_boundary;
            S_MEM_WR:   w_next = w_boundary;
            S_R_EXEC:   w_next = S_R_WB;
            S_R_WB:     w_next = w_boundary;
            S_I_EXEC:   w_next = S_I_WB;
            S_I_WB:     w_next = w_boundary;
            S_BRANCH:   w_next = w_boundary;
            S_JUMP:     w_next = w_boundary;
            S_JAL:      w_next = w_boundary;
            S_INT:      w_next = S_FETCH;
            S_ERET:     w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // State and handler-active registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_in_isr <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_INT)
                r_in_isr <= 1'b1;
            else if (r_state == S_ERET)
                r_in_isr <= 1'b0;
        end
    end

    // Moore output decode; everything held low during reset.
    always_comb begin
        bus.alu_op        = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.wreg_dst      = 2'b00;
        bus.wreg_data_sel = 2'b00;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.reg_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.imm_com       = 1'b0;
        bus.int_save_pc   = 1'b0;
        bus.pc_source     = 3'b000;
        bus.int_ack       = 1'b0;
        bus.illegal_op    = 1'b0;
        bus.in_isr        = 1'b0;
        if (!rst) begin
            bus.in_isr = r_in_isr;
            case (r_state)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.ir_write  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.pc_write  = 1'b1;
                end
                S_DECODE: begin
                    bus.alu_src_b  = 2'b11;
                    bus.illegal_op = w_dec_ill;
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.wreg_data_sel = 2'b01;
                end
                S_MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                end
                S_R_WB: begin
                    bus.reg_write = 1'b1;
                    bus.wreg_dst  = 2'b01;
                    bus.alu_op    = 2'b10;
                end
                S_I_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = 2'b10;
                    bus.imm_com   = 1'b1;
                end
                S_I_WB: begin
                    bus.reg_write = 1'b1;
                    bus.imm_com   = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 3'b001;
                end
                S_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 3'b010;
                end
                S_JAL: begin
                    bus.pc_write      = 1'b1;
                    bus.pc_source     = 3'b010;
                    bus.reg_write     = 1'b1;
                    bus.wreg_dst      = 2'b10;
                    bus.wreg_data_sel = 2'b10;
                end
                S_INT: begin
                    bus.int_save_pc = 1'b1;
                    bus.pc_write    = 1'b1;
                    bus.pc_source   = 3'b011;
                    bus.int_ack     = 1'b1;
                end
                S_ERET: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 3'b100;
                end
                default: ;
            endcase
        end
    end

endmodule
